// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, reader state and column-major address helper for the 2-D DCT
package dct_pkg;
    localparam int DCT_N   = 8;
    localparam int DCT_BLK = DCT_N * DCT_N;
    localparam int DCT_DW  = 10;

    typedef enum logic {IDLE, READ} rd_state_t;

    // rcnt walks column-major: row = rcnt[2:0], col = rcnt[5:3], so the address is row*8 + col
    function automatic logic [5:0] tp_addr(input logic [5:0] rcnt);
        return {rcnt[2:0], rcnt[5:3]};
    endfunction
endpackage

// File: rtl/tp_bank_mem.sv
// tp_bank_mem: 2x64xDW ping-pong register file, synchronous write, combinational read
module tp_bank_mem #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [5:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rbank,
    input  logic [5:0]    raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2][64];

    // contents are deliberately not reset; full flags in the controller guard every read
    always_ff @(posedge clk) begin
        if (we) mem[wbank][waddr] <= wdata;
    end

    assign rdata = mem[rbank][raddr];
endmodule

// File: rtl/dct_tp_ctrl.sv
// dct_tp_ctrl: captures row-major blocks into a ping-pong buffer and replays them column-major
module dct_tp_ctrl
    import dct_pkg::*;
#(
    parameter int DW = DCT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tp_enb,
    input  logic [DW-1:0] tp_data,
    input  logic          col_hold,
    output logic          col_enb,
    output logic [DW-1:0] col_data,
    output logic          col_first,
    output logic          col_last,
    output logic          ovf
);
    localparam logic [5:0] LAST = 6'(DCT_BLK - 1);

    rd_state_t     state, state_d;
    logic          wb, rb;
    logic [5:0]    wcnt, rcnt;
    logic [1:0]    full, full_d;
    logic          rd_go, rd_wrap, wr_ok;
    logic [DW-1:0] rdata;

    tp_bank_mem #(.DW(DW)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .wbank (wb),
        .waddr (wcnt),
        .wdata (tp_data),
        .rbank (rb),
        .raddr (tp_addr(rcnt)),
        .rdata (rdata)
    );

    // next state, write legality and bank flag updates; a write into the bank being drained lands only on its final read
    always_comb begin
        rd_go   = (state == READ) && !col_hold;
        rd_wrap = rd_go && (rcnt == LAST);
        wr_ok   = tp_enb && (!full[wb] || (rd_wrap && (rb == wb)));
        full_d  = full;
        if (rd_wrap) full_d[rb] = 1'b0;
        if (wr_ok && (wcnt == LAST)) full_d[wb] = 1'b1;
        state_d = state;
        if (state == IDLE) state_d = full[rb] ? READ : IDLE;
        else if (rd_wrap) state_d = full[~rb] ? READ : IDLE;
    end

    // reader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_d;
    end

    // counters, bank selects, flags and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb        <= 1'b0;
            rb        <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            full      <= '0;
            ovf       <= 1'b0;
            col_enb   <= 1'b0;
            col_first <= 1'b0;
            col_last  <= 1'b0;
            col_data  <= '0;
        end else begin
            full <= full_d;
            if (wr_ok) begin
                wcnt <= wcnt + 6'd1;
                if (wcnt == LAST) wb <= ~wb;
            end
            if (tp_enb && !wr_ok) ovf <= 1'b1;
            col_enb   <= rd_go;
            col_first <= rd_go && (rcnt == '0);
            col_last  <= rd_wrap;
            if (rd_go) begin
                col_data <= rdata;
                rcnt     <= rcnt + 6'd1;
            end
            if (rd_wrap) rb <= ~rb;
        end
    end
endmodule

// File: tb/tb_dct_tp_ctrl.sv
// tb_dct_tp_ctrl: directed self-checking bench for the transpose-buffer controller
module tb_dct_tp_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tp_enb = 1'b0;
    logic [9:0] tp_data = '0;
    logic       col_hold = 1'b0;
    logic       col_enb, col_first, col_last, ovf;
    logic [9:0] col_data;

    int cyc = 0;
    int errs = 0;
    int checks = 0;
    int qd[$];
    int qf[$];
    int ql[$];
    int qc[$];
    int last_in;

    dct_tp_ctrl #(.DW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .tp_enb    (tp_enb),
        .tp_data   (tp_data),
        .col_hold  (col_hold),
        .col_enb   (col_enb),
        .col_data  (col_data),
        .col_first (col_first),
        .col_last  (col_last),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (col_enb) begin
            qd.push_back(int'(col_data));
            qf.push_back(int'(col_first));
            ql.push_back(int'(col_last));
            qc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qd.delete();
        qf.delete();
        ql.delete();
        qc.delete();
    endtask

    function automatic int cm(input int base, input int k);
        return base + (k % 8) * 8 + k / 8;
    endfunction

    task automatic send_block(input int base, input int gap, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            tp_enb  = 1'b1;
            tp_data = 10'(base + i);
            tick();
            if (i == 63) last_cyc = cyc;
            if (gap != 0) begin
                tp_enb = 1'b0;
                tick();
            end
        end
        tp_enb = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int n);
        for (int t = 0; t < 2000 && qd.size() < n; t++) tick();
        chk({tag, "_count"}, qd.size(), n);
    endtask

    task automatic check_block(input string tag, input int off, input int base);
        int nf, nl;
        nf = 0;
        nl = 0;
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("%s_d%0d", tag, k), qd[off+k], cm(base, k));
            nf += qf[off+k];
            nl += ql[off+k];
        end
        chk({tag, "_first_pos"}, qf[off], 1);
        chk({tag, "_last_pos"}, ql[off+63], 1);
        chk({tag, "_first_cnt"}, nf, 1);
        chk({tag, "_last_cnt"}, nl, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_enb", int'(col_enb), 0);
        chk("rst_data", int'(col_data), 0);
        chk("rst_first", int'(col_first), 0);
        chk("rst_last", int'(col_last), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b1;
        repeat (2) tick();

        clear_q();
        send_block(0, 0, last_in);
        wait_out("single", 64);
        chk("single_lat", qc[0] - last_in, 2);
        chk("single_span", qc[63] - qc[0], 63);
        check_block("single", 0, 0);
        repeat (10) tick();

        clear_q();
        send_block(0, 0, last_in);
        send_block(100, 0, last_in);
        wait_out("b2b", 128);
        chk("b2b_span", qc[127] - qc[0], 127);
        check_block("b2b_a", 0, 0);
        check_block("b2b_b", 64, 100);
        chk("b2b_ovf", int'(ovf), 0);
        repeat (10) tick();

        clear_q();
        send_block(0, 1, last_in);
        wait_out("gap", 64);
        chk("gap_lat", qc[0] - last_in, 2);
        check_block("gap", 0, 0);
        repeat (10) tick();

        clear_q();
        col_hold = 1'b1;
        send_block(0, 0, last_in);
        send_block(100, 0, last_in);
        send_block(200, 0, last_in);
        repeat (5) tick();
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_no_out", qd.size(), 0);
        col_hold = 1'b0;
        wait_out("ovf", 128);
        chk("ovf_span", qc[127] - qc[0], 127);
        check_block("ovf_1", 0, 0);
        check_block("ovf_2", 64, 100);
        repeat (20) tick();
        chk("ovf_dropped", qd.size(), 128);
        chk("ovf_sticky", int'(ovf), 1);
        rst = 1'b0;
        tick();
        chk("ovf_rst", int'(ovf), 0);
        rst = 1'b1;
        repeat (2) tick();

        clear_q();
        send_block(0, 0, last_in);
        for (int t = 0; t < 500 && qd.size() < 20; t++) begin
            @(negedge clk);
            #1;
        end
        chk("hold_reach", qd.size(), 20);
        col_hold = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("hold_enb", int'(col_enb), 0);
        chk("hold_data", int'(col_data), cm(0, 19));
        repeat (3) @(negedge clk);
        col_hold = 1'b0;
        wait_out("hold", 64);
        chk("hold_gap", qc[20] - qc[19], 6);
        chk("hold_span", qc[63] - qc[0], 68);
        check_block("hold", 0, 0);
        repeat (10) tick();

        clear_q();
        for (int i = 0; i < 30; i++) begin
            tp_enb  = 1'b1;
            tp_data = 10'(500 + i);
            tick();
        end
        tp_enb = 1'b0;
        rst = 1'b0;
        #1;
        chk("mrst_enb", int'(col_enb), 0);
        chk("mrst_data", int'(col_data), 0);
        chk("mrst_ovf", int'(ovf), 0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        send_block(0, 0, last_in);
        wait_out("mrst", 64);
        chk("mrst_lat", qc[0] - last_in, 2);
        check_block("mrst", 0, 0);
        repeat (20) tick();
        chk("mrst_total", qd.size(), 64);
        chk("mrst_ovf_end", int'(ovf), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
